flush_redirect_ctrl: RTL

FLUSH_REDIRECT_CTRL -- requirements
Module: flush_redirect_ctrl

---
 rtl/flush_redirect_ctrl_pkg.sv | 18 +
 rtl/flush_redirect_ctrl_discard_cnt.sv | 52 +++++
 rtl/flush_redirect_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared state encodings, counter width and exception vector for flush_redirect_ctrl.
// FLUSH_MULTI_OUTSTANDING_EN selects 2-bit counters (3 fetches in flight); the default is 1 fetch.
package flush_redirect_ctrl_pkg;

`ifdef FLUSH_MULTI_OUTSTANDING_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 1;
`endif

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

endpackage

// File: rtl/flush_redirect_ctrl_discard_cnt.sv
// Tracks in-flight instruction fetches and how many of their responses are stale after a flush.
// discard_rdata is combinational with the response; counts update on the next edge; no backpressure.
module if_discard_cnt
  import flush_redirect_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fetch_acc,
  input  logic resp_vld,
  input  logic flush,
  output logic discard_rdata,
  output logic discard_pend
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  always_comb begin
    outst_d = outst_q;
    if (fetch_acc && !resp_vld && (outst_q != CNT_MAX)) begin
      outst_d = outst_q + 1'b1;
    end else if (resp_vld && !fetch_acc && (outst_q != '0)) begin
      outst_d = outst_q - 1'b1;
    end
  end

  // Loading the post-update count keeps a same-cycle response out of the discard budget.
  always_comb begin
    discard_d = discard_q;
    if (flush) begin
      discard_d = outst_d;
    end else if (resp_vld && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end
  end

  assign discard_rdata = rst & resp_vld & (flush | (discard_q != '0));
  assign discard_pend  = (discard_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Flush decode and redirect FSM; flushes are same-cycle, the redirect PC is offered from the next cycle.
// Redirect is held until IF asserts redirect_ready; FLUSH_MULTI_OUTSTANDING_EN widens fetch tracking.
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  input  logic        flush_by_i1,
  input  logic        flush_by_i2,
  input  logic        inst_req,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        redirect_ready,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        flush_mem_i2,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        discard_rdata,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        discard_pend;
  logic        slot1_cause;

  // Slot 1 is older, so it owns the flush even when slot 2 also reports one.
  assign slot1_cause = flush_by_i1 | (flush_by_i1 & flush_by_i2);

  if_discard_cnt u_discard_cnt (
    .clk           (clk),
    .rst           (rst),
    .fetch_acc     (inst_req & inst_addr_ok),
    .resp_vld      (inst_data_ok),
    .flush         (flush_req),
    .discard_rdata (discard_rdata),
    .discard_pend  (discard_pend)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // A flush arriving while a redirect is pending replaces it: newest target wins.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = flush_req ? flush_pc : redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (!flush_req && redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = (state_q == ST_REDIRECT);
    flush_if       = flush_req | redirect_valid;
    flush_id       = flush_req;
    flush_ex       = flush_req;
    flush_mem_i2   = flush_req & slot1_cause;
    busy           = redirect_valid | discard_pend;
  end

  assign redirect_pc = redirect_pc_q;

endmodule
